// File: rtl/fir_inverse_filter_pkg.sv
// Shared DSP definitions for the FIR / inverse-FIR pair.
// Both ends import the same tap count and coefficient vector, so the encoder and
// the decoder always agree on the filter. Also holds the FSM state encoding and
// the 16-bit saturating clip.
package fir_inverse_filter_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned FIR_OUT_W = 32;
  localparam int unsigned FIR_N     = 4;
  localparam int unsigned SAT_IN_W  = 64;

  // Packed b[N-1..0]. b[0] is the monic tap and is never read by the decoder.
  localparam logic [FIR_N*SAMPLE_W-1:0] FIR_COEFS = {16'sd4, 16'sd3, 16'sd2, 16'sd1};

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 64'sd32767;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -64'sd32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic                       clip;
    logic signed [SAMPLE_W-1:0] val;
  } sat_res_t;

  // Clip a wide signed value to the 16-bit sample range and flag the clipping.
  function automatic sat_res_t sat16(input logic signed [SAT_IN_W-1:0] v);
    sat_res_t r;
    if (v > SAT_MAX) begin
      r.clip = 1'b1;
      r.val  = 16'sh7fff;
    end else if (v < SAT_MIN) begin
      r.clip = 1'b1;
      r.val  = 16'sh8000;
    end else begin
      r.clip = 1'b0;
      r.val  = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_mac_sat.sv
// Shared signed 16x16 multiply, subtract-accumulate and saturating output stage.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   load/load_val  overwrite the accumulator with load_val
//   mac            acc <= acc - coef*sample
//   coef, sample   signed 16-bit multiplier operands
//   sat_val_c      clip16(acc - coef*sample), combinational
//   sat_clip_c     the value above was clipped, combinational
module dsp_mac_sat
  import fir_inverse_filter_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic signed [ACC_W-1:0]    load_val,
  input  logic                       mac,
  input  logic signed [SAMPLE_W-1:0] coef,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic signed [SAMPLE_W-1:0] sat_val_c,
  output logic                       sat_clip_c
);

  localparam int unsigned PROD_W = 2 * SAMPLE_W;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_diff_c;
  sat_res_t                 res_c;

  // Full-precision product, then sign-extended into the accumulator width.
  assign prod_c     = PROD_W'(coef) * PROD_W'(sample);
  assign acc_diff_c = acc_q - ACC_W'(prod_c);

  // Saturation looks at the post-subtract value so the last MAC step can be
  // captured straight into the output register.
  assign res_c      = sat16(SAT_IN_W'(acc_diff_c));
  assign sat_val_c  = res_c.val;
  assign sat_clip_c = res_c.clip;

  // Accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= load_val;
    end else if (mac) begin
      acc_q <= acc_diff_c;
    end
  end

endmodule

// File: rtl/fir_inverse_filter.sv
// Inverse (deconvolution) filter: recovers x[n] from the FIR output z[n] using
// y[n] = z[n] - sum_{k=1..N-1} b[k]*y[n-k], on one time-shared MAC.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready/zn  32-bit signed FIR sample input handshake
//   out_valid/out_ready   recovered sample output handshake
//   yn                    16-bit signed recovered sample, saturated
//   sat                   yn was clipped (qualified by out_valid)
module fir_inverse_filter
  import fir_inverse_filter_pkg::*;
#(
  parameter int unsigned                N     = FIR_N,
  parameter logic [N*SAMPLE_W-1:0]      COEFS = FIR_COEFS,
  parameter int unsigned                ACC_W = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [FIR_OUT_W-1:0] zn,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [SAMPLE_W-1:0]  yn,
  output logic                        sat
);

  localparam int unsigned K_W = $clog2(N);
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  fsm_state_t                 state_q, state_d;
  logic [K_W-1:0]             k_q, k_d;
  logic signed [SAMPLE_W-1:0] yn_q, yn_d;
  logic                       sat_q, sat_d;
  logic                       out_valid_q, out_valid_d;
  logic                       in_ready_q, in_ready_d;
  logic                       acc_load_c, acc_mac_c, hist_shift_c;

  // hist_q[k] holds y[n-k].
  logic signed [SAMPLE_W-1:0] hist_q [1:N-1];
  logic signed [SAMPLE_W-1:0] coef_c;
  logic signed [SAMPLE_W-1:0] hist_c;
  logic signed [SAMPLE_W-1:0] sat_val_c;
  logic                       sat_clip_c;

  assign coef_c = COEFS[SAMPLE_W*int'(k_q) +: SAMPLE_W];
  assign hist_c = hist_q[k_q];

  // Shared MAC: one tap per cycle.
  dsp_mac_sat #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk        (clk),
    .reset      (reset),
    .load       (acc_load_c),
    .load_val   (ACC_W'(zn)),
    .mac        (acc_mac_c),
    .coef       (coef_c),
    .sample     (hist_c),
    .sat_val_c  (sat_val_c),
    .sat_clip_c (sat_clip_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    yn_d         = yn_q;
    sat_d        = sat_q;
    out_valid_d  = out_valid_q;
    acc_load_c   = 1'b0;
    acc_mac_c    = 1'b0;
    hist_shift_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_load_c = 1'b1;
          k_d        = K_W'(1);
          state_d    = MAC;
        end
      end
      MAC: begin
        acc_mac_c = 1'b1;
        k_d       = k_q + K_W'(1);
        // Final tap: capture the clipped result directly as the output beat.
        if (k_q == K_LAST) begin
          yn_d        = sat_val_c;
          sat_d       = sat_clip_c;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        // Output handshake only; a new input waits for the next IDLE cycle.
        if (out_ready) begin
          out_valid_d  = 1'b0;
          hist_shift_c = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      yn_q        <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      yn_q        <= yn_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // History shift: the saturated output, not the raw accumulator, feeds back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < N; i++) hist_q[i] <= '0;
    end else if (hist_shift_c) begin
      hist_q[1] <= yn_q;
      for (int i = 2; i < N; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign yn        = yn_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Self-checking bench for fir_inverse_filter with default parameters.
module tb_fir_inverse_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] zn;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] yn;
  logic               sat;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: feedback taps b[1..3] and the last three recovered samples.
  int     b  [1:3] = '{2, 3, 4};
  longint mh [1:3];

  always #5 clk = ~clk;

  fir_inverse_filter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .zn        (zn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .yn        (yn),
    .sat       (sat)
  );

  task automatic model_clear();
    for (int k = 1; k <= 3; k++) mh[k] = 0;
  endtask

  task automatic model_step(input longint z, output int y, output bit s);
    longint a;
    a = z;
    for (int k = 1; k <= 3; k++) a -= longint'(b[k]) * mh[k];
    if (a > 32767)       begin y = 32767;  s = 1'b1; end
    else if (a < -32768) begin y = -32768; s = 1'b1; end
    else                 begin y = int'(a); s = 1'b0; end
    for (int k = 3; k > 1; k--) mh[k] = mh[k-1];
    mh[1] = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; zn = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic signed [31:0] z, input string name);
    int t = 0;
    in_valid = 1'b1; zn = z;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (t >= 40) begin
      miscompares++;
      $display("FAIL %s accept timeout: in_ready=%b required 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; zn = $urandom;
  endtask

  task automatic recv(input int ey, input bit es, input string name);
    int t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (!out_valid || yn !== 16'(ey) || sat !== es) begin
      miscompares++;
      $display("FAIL %s: out_valid=%b yn=%0d sat=%b, required out_valid=1 yn=%0d sat=%b",
               name, out_valid, yn, sat, ey, es);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; zn = '0;
    #12;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || yn !== 16'sd0 || sat !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b yn=%0d sat=%b, required 0 0 0 0",
               in_ready, out_valid, yn, sat);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_no_edge: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_edge: in_ready=%b required 1", in_ready);
    end
    model_clear();
  endtask

  task automatic test_impulse();
    int z  [5] = '{1, 0, 0, 0, 0};
    int ey [5] = '{1, -2, 1, 0, 5};
    int y; bit s;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(32'(z[i]), "impulse");
      model_step(z[i], y, s);
      recv(ey[i], 1'b0, "impulse");
    end
  endtask

  task automatic test_round_trip();
    int z  [4] = '{10, 40, 65, 90};
    int ey [4] = '{10, 20, -5, 0};
    int y; bit s;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(32'(z[i]), "round_trip");
      model_step(z[i], y, s);
      recv(ey[i], 1'b0, "round_trip");
    end
  endtask

  task automatic test_saturation();
    int y; bit s;
    do_reset();
    send(32'sd40000, "sat_pos");
    model_step(40000, y, s);
    recv(32767, 1'b1, "sat_pos");
    send(32'sd0, "sat_neg");
    model_step(0, y, s);
    recv(-32768, 1'b1, "sat_neg");
  endtask

  task automatic test_latency_throughput();
    int     acc_cyc [$];
    longint acc_z   [$];
    int     last_acc = -1;
    int     n_acc = 0;
    int     y; bit s;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    zn = $signed(32'($urandom_range(0, 40))) - 32'sd20;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (out_valid) begin
        vectors++;
        if (acc_cyc.size() == 0) begin
          miscompares++;
          $display("FAIL lat_stray_beat: out_valid=1 at cycle %0d, required no beat", cyc);
        end else begin
          int a; longint z;
          a = acc_cyc.pop_front();
          z = acc_z.pop_front();
          model_step(z, y, s);
          if (cyc - a != 4 || yn !== 16'(y) || sat !== s) begin
            miscompares++;
            $display("FAIL latency: %0d cycles yn=%0d sat=%b, required 4 cycles yn=%0d sat=%b",
                     cyc - a, yn, sat, y, s);
          end
        end
      end
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        acc_z.push_back(longint'(zn));
        n_acc++;
        if (last_acc >= 0) begin
          vectors++;
          if (cyc - last_acc != 5) begin
            miscompares++;
            $display("FAIL throughput: accept interval %0d required 5", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      @(negedge clk);
      if (cyc == 40) in_valid = 1'b0;
      zn = $signed(32'($urandom_range(0, 40))) - 32'sd20;
    end
    vectors++;
    if (acc_cyc.size() != 0 || n_acc < 7) begin
      miscompares++;
      $display("FAIL lat_drain: pending=%0d accepts=%0d, required pending=0 accepts>=7",
               acc_cyc.size(), n_acc);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int y; bit s; int t = 0; int bad = 0;
    do_reset();
    send(32'sd10, "bp_first");
    model_step(10, y, s);
    recv(10, 1'b0, "bp_first");
    send(32'sd40, "bp_hold");
    model_step(40, y, s);
    while (!out_valid && t < 40) begin @(negedge clk); t++; end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      zn = $urandom;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || yn !== 16'sd20 || sat !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++; bad++;
        $display("FAIL backpressure: out_valid=%b yn=%0d sat=%b in_ready=%b, required 1 20 0 0",
                 out_valid, yn, sat, in_ready);
      end
    end
    in_valid = 1'b0;
    recv(20, 1'b0, "bp_release");
    send(32'sd65, "bp_after");
    model_step(65, y, s);
    recv(-5, 1'b0, "bp_after");
  endtask

  task automatic test_reset_mid_mac();
    int y; bit s; int stale = 0;
    do_reset();
    send(32'sd100, "rm_prime");
    model_step(100, y, s);
    recv(100, 1'b0, "rm_prime");
    send(32'sd50, "rm_abort");
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || yn !== 16'sd0 || sat !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_async_clear: out_valid=%b in_ready=%b yn=%0d sat=%b, required 0 0 0 0",
               out_valid, in_ready, yn, sat);
    end
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    vectors++;
    if (stale != 0) begin
      miscompares++;
      $display("FAIL rm_stale_beat: %0d out_valid cycles, required 0", stale);
    end
    send(32'sd7, "rm_fresh");
    model_step(7, y, s);
    recv(7, 1'b0, "rm_fresh");
  endtask

  task automatic test_random();
    int y; bit s; logic signed [31:0] z;
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) do_reset();
      if ($urandom_range(0, 3) == 0) z = $signed($urandom);
      else z = $signed(32'($urandom_range(0, 600))) - 32'sd300;
      send(z, "random");
      model_step(longint'(z), y, s);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      recv(y, s, "random");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_impulse();
    test_round_trip();
    test_saturation();
    test_latency_throughput();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
